// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver (8N1, LSB first, idle-high).
// A start edge is qualified at mid start bit. Each following bit is sampled
// once per OVERSAMPLE ticks at the bit centre. The stop bit is checked for
// framing errors.
// Optional build macro: UART_RX_PARITY_EN selects an 8E1 frame, which adds a
// parity bit before the stop bit and a parity_err output.
//
// Handshake: rx_done is a single-clk strobe with no back-pressure. rx_data,
// frame_err and parity_err become valid in the same clk as rx_done. They then
// hold until the next rx_done.
module uart_rx_oversampled #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   line_ok_q, line_ok_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_done_q, rx_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit_q, parity_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // Synchronised serial input; bit 0 takes the raw pin
  assign rx_s = sync_q[SYNC_STAGES-1];

  // Metastability chain on the asynchronous pin, idle-high at reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_bit};
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      line_ok_q    <= 1'b1;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      line_ok_q    <= line_ok_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: everything except the rx_done strobe advances only on tick
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    line_ok_d    = line_ok_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = parity_err_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          // After a framing error the line must return high before a new
          // start edge is accepted, so a held break does not retrigger.
          if (rx_s) begin
            line_ok_d = 1'b1;
          end else if (line_ok_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (tick_cnt_q == TICK_HALF) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d   = '0;
            parity_bit_d = rx_s;
            state_d      = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d  = '0;
            rx_data_d   = shift_q;
            frame_err_d = ~rx_s;
            line_ok_d   = rx_s;
            rx_done_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^shift_q) ^ parity_bit_q;
`endif
            state_d = S_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output mapping
  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed bench for uart_rx_oversampled.
// The bench runs OVERSAMPLE=16 with one tick every 4 clks, so a bit lasts 64 clks.
module tb_uart_rx_oversampled;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       rx_bit;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks;
  int n_fail;
  int done_cnt;
  int done_long;
  logic       tick_en;
  logic       prev_done;
  logic [7:0] got_data_q[$];
  logic       got_ferr_q[$];
  logic       got_perr_q[$];
  logic [7:0] exp_q[$];

  uart_rx_oversampled #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx_bit    (rx_bit),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick generator: one-clk pulse every 4 clks, gated by tick_en
  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (cnt == 3) && tick_en;
      cnt  = (cnt + 1) % 4;
    end
  end

  // Monitor: capture every rx_done strobe and flag strobes longer than one clk
  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done === 1'b1) begin
        done_cnt++;
        got_data_q.push_back(rx_data);
        got_ferr_q.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
        got_perr_q.push_back(parity_err);
`else
        got_perr_q.push_back(1'b0);
`endif
        if (prev_done) done_long++;
      end
      prev_done = (rx_done === 1'b1);
    end
  end

  // Driver tasks
  task automatic send_bit(input logic v);
    rx_bit = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v);
`else
    if (par_v) begin end
`endif
    send_bit(stop_v);
  endtask

  // Compare the oldest captured frame with the oldest expected byte
  task automatic check_frame(input string name, input logic exp_ferr);
    logic [7:0] exp_d;
    logic [7:0] got_d;
    logic       got_f;
    exp_d = exp_q.pop_front();
    n_checks++;
    if (got_data_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no rx_done captured, expected rx_data=%02h", name, exp_d);
    end else begin
      got_d = got_data_q.pop_front();
      got_f = got_ferr_q.pop_front();
      void'(got_perr_q.pop_front());
      if (got_d !== exp_d) begin
        n_fail++;
        $display("FAIL %s data: got %02h expected %02h", name, got_d, exp_d);
      end
      n_checks++;
      if (got_f !== exp_ferr) begin
        n_fail++;
        $display("FAIL %s frame_err: got %b expected %b", name, got_f, exp_ferr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_data, rx_done, frame_err, rx_busy} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%02h done=%b ferr=%b busy=%b expected all 0",
               rx_data, rx_done, frame_err, rx_busy);
    end
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_quiet: got %0d rx_done expected 0", done_cnt);
    end
  endtask

  task automatic test_basic_frame();
    int n0;
    n0 = done_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    n_checks++;
    if (done_cnt - n0 !== 1) begin
      n_fail++;
      $display("FAIL basic_pulses: got %0d expected 1", done_cnt - n0);
    end
    check_frame("basic_55", 1'b0);
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_after: got %b expected 0", rx_busy);
    end
    send_bit(1'b1);
  endtask

  task automatic test_framing_break();
    int n0;
    n0 = done_cnt;
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b0, 1'b0);
    check_frame("ferr_A3", 1'b1);
    n0 = done_cnt;
    repeat (3) send_bit(1'b0);
    n_checks++;
    if (done_cnt !== n0) begin
      n_fail++;
      $display("FAIL break_no_retrigger: got %0d extra rx_done expected 0", done_cnt - n0);
    end
    send_bit(1'b1);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    check_frame("after_break_01", 1'b0);
    send_bit(1'b1);
  endtask

  task automatic test_glitch();
    int n0;
    int waited;
    logic [7:0] data0;
    n0    = done_cnt;
    data0 = rx_data;
    rx_bit = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_rise: got %b expected 1", rx_busy);
    end
    rx_bit = 1'b1;
    waited = 0;
    while (rx_busy === 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_fall: got %b expected 0 within 40 clks", rx_busy);
    end
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_checks++;
    if (done_cnt !== n0 || rx_data !== data0) begin
      n_fail++;
      $display("FAIL glitch_no_frame: got %0d pulses data=%02h expected 0 pulses data=%02h",
               done_cnt - n0, rx_data, data0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = done_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    n_checks++;
    if (done_cnt - n0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d expected 2", done_cnt - n0);
    end
    check_frame("b2b_00", 1'b0);
    check_frame("b2b_FF", 1'b0);
    send_bit(1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    logic [7:0] d;
    d  = 8'h3C;
    n0 = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_bit = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst    = 1'b1;
    rx_bit = 1'b1;
    #1;
    n_checks++;
    if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async: got busy=%b data=%02h expected busy=0 data=00", rx_busy, rx_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_checks++;
    if (done_cnt !== n0 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_discard: got %0d pulses data=%02h expected 0 pulses data=00",
               done_cnt - n0, rx_data);
    end
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b0);
    check_frame("after_rst_96", 1'b0);
    send_bit(1'b1);
  endtask

  task automatic test_tick_stuck();
    int n0;
    n0 = done_cnt;
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    rx_bit = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b0 || done_cnt !== n0) begin
      n_fail++;
      $display("FAIL tick_stuck_freeze: got busy=%b pulses=%0d expected busy=0 pulses=0",
               rx_busy, done_cnt - n0);
    end
    rx_bit = 1'b1;
    repeat (10) @(negedge clk);
    tick_en = 1'b1;
    send_bit(1'b1);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic p;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, (k == 0) ? 1'b1 : 1'b0);
      n_checks++;
      p = (got_perr_q.size() > 0) ? got_perr_q[0] : 1'bx;
      if (p !== ((k == 0) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL parity_%0d: got parity_err=%b expected %b", k, p, (k == 0) ? 1'b0 : 1'b1);
      end
      check_frame("parity_07", 1'b0);
      send_bit(1'b1);
    end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    done_cnt  = 0;
    done_long = 0;
    tick_en   = 1'b1;
    rx_bit    = 1'b1;
    rst       = 1'b1;
    test_reset();
    test_basic_frame();
    test_framing_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_tick_stuck();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (done_long !== 0) begin
      n_fail++;
      $display("FAIL done_width: got %0d strobes longer than 1 clk expected 0", done_long);
    end
    n_checks++;
    if (got_data_q.size() !== 0) begin
      n_fail++;
      $display("FAIL spurious_frames: got %0d unexpected rx_done expected 0", got_data_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
